// File: rtl/com_tpram_arb_pkg.sv
// com_tpram_arb_pkg: shared types and helpers for the two-port RAM arbiter.
//   state_e   : controller state (ST_INIT sweep, ST_RUN normal operation)
//   OH_MAX    : widest one-hot vector accepted by oh2idx (max read requesters)
//   oh2idx()  : one-hot to binary index conversion
package com_tpram_arb_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

  localparam int unsigned OH_MAX = 16;

  // Zero input yields index 0; callers qualify the index with a valid flag.
  function automatic logic [3:0] oh2idx(input logic [OH_MAX-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/com_rr_arb.sv
// com_rr_arb: round-robin arbiter with a hold input.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[N]     : request vector
//   hold       : suppress the grant and the pointer update this cycle
//   gnt[N]     : one-hot grant (zero when hold or no request)
//   gnt_idx    : index of the candidate winner, valid whenever any req is set,
//                independent of hold so the caller can derive hold from it
module com_rr_arb
  import com_tpram_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             hold,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pos;
  logic [N-1:0]     cand;

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    cand = '0;
    pos  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IDX_W'((32'(last_q) + 1 + k) % N);
      if (cand == '0 && req[pos]) cand[pos] = 1'b1;
    end
  end

  always_comb begin
    gnt_idx = IDX_W'(oh2idx(OH_MAX'(cand)));
    gnt     = hold ? '0 : cand;
    last_d  = (!hold && (|cand)) ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDX_W'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/com_tpram_arb.sv
// com_tpram_arb: shares one two-port RAM between one writer and RD_N readers.
// Optional post-reset zero sweep is enabled by defining COM_TPRAM_ARB_INIT_EN.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_vld/wr_rdy/wr_strb/
//   wr_addr/wr_data            : write request (passed through to the RAM)
//   rd_req/rd_addr/rd_gnt      : per-requester read request, address, grant
//   rsp_vld/rsp_data           : one-hot response id and read data
//   init_done                  : array usable
//   ram_wr_*/ram_rd_*          : RAM write and read ports (read latency 1)
module com_tpram_arb
  import com_tpram_arb_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned STRB_W = 1,
  parameter  int unsigned RD_N   = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [STRB_W-1:0]      wr_strb,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [RD_N-1:0]        rd_req,
  input  logic [RD_N*ADDR_W-1:0] rd_addr,
  output logic [RD_N-1:0]        rd_gnt,
  output logic [RD_N-1:0]        rsp_vld,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   init_done,
  output logic [STRB_W-1:0]      ram_wr_en,
  output logic [ADDR_W-1:0]      ram_wr_addr,
  output logic [DATA_W-1:0]      ram_wr_data,
  output logic                   ram_rd_en,
  output logic [ADDR_W-1:0]      ram_rd_addr,
  input  logic [DATA_W-1:0]      ram_rd_data
);

  localparam int unsigned IDX_W = (RD_N > 1) ? $clog2(RD_N) : 1;

  logic              in_init;
  logic              in_run;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef COM_TPRAM_ARB_INIT_EN
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign in_init    = rst_n & (state_q == ST_INIT);
  assign in_run     = rst_n & (state_q == ST_RUN);
  assign sweep_addr = init_cnt_q;
  assign init_done  = (state_q == ST_RUN);
`else
  assign in_init    = 1'b0;
  assign in_run     = rst_n;
  assign sweep_addr = '0;
  assign init_done  = 1'b1;
`endif

  // Write path: sweep zeros during INIT, otherwise pass the request through.
  always_comb begin
    wr_rdy      = in_run;
    ram_wr_en   = '0;
    ram_wr_addr = wr_addr;
    ram_wr_data = wr_data;
    if (in_init) begin
      ram_wr_en   = '1;
      ram_wr_addr = sweep_addr;
      ram_wr_data = '0;
    end else if (in_run && wr_vld) begin
      ram_wr_en = wr_strb;
    end
  end

  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              collision;
  logic              arb_hold;

  // A read of the address being written this cycle is deferred one cycle so
  // it returns the new data instead of relying on RAM read-during-write.
  assign win_addr  = rd_addr[32'(win_idx) * ADDR_W +: ADDR_W];
  assign collision = wr_vld & (|wr_strb) & (win_addr == wr_addr);
  assign arb_hold  = ~in_run | collision;

  com_rr_arb #(.N(RD_N)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .hold    (arb_hold),
    .gnt     (rd_gnt),
    .gnt_idx (win_idx)
  );

  assign ram_rd_en   = |rd_gnt;
  assign ram_rd_addr = win_addr;

  logic [RD_N-1:0] rsp_q, rsp_d;

  assign rsp_d = rd_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_q <= '0;
    else        rsp_q <= rsp_d;
  end

  assign rsp_vld  = rsp_q;
  assign rsp_data = ram_rd_data;

endmodule
